// File: rtl/seq_detector.sv
// seq_detector: serial pattern matcher with overlap/non-overlap modes; SEQ_DETECTOR_COUNT_EN adds a saturating match counter
module seq_detector #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    localparam int SW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic             x,
    input  logic [WIDTH-1:0] pattern,
    input  logic             ld,
    input  logic             overlap,
    input  logic             clear,
    output logic             match,
    output logic [SW-1:0]    state
`ifdef SEQ_DETECTOR_COUNT_EN
    ,
    output logic [CNT_W-1:0] count
`endif
);
    localparam logic [SW-1:0] FULL = SW'(WIDTH);
    logic [WIDTH-1:0] pat_q, hist, hist_n;
    logic [SW-1:0]    fill, fill_n;
    logic             hit;
    always_comb begin
        hist_n = {hist[WIDTH-2:0], x};
        fill_n = (fill == FULL) ? fill : fill + SW'(1);
        hit    = (hist_n == pat_q) && (fill_n == FULL);
    end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pat_q <= '0;
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (clear) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (ld) begin
            pat_q <= pattern;
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (en) begin
            hist  <= hist_n;
            fill  <= (hit && !overlap) ? '0 : fill_n;
            match <= hit;
        end else begin
            match <= 1'b0;
        end
    end
    assign state = fill;
`ifdef SEQ_DETECTOR_COUNT_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (!ld && en && hit && !(&count))
            count <= count + CNT_W'(1);
    end
`endif
endmodule
